pipe_hazard_ctrl: RTL and testbench

- Central hazard/stall controller for the 5-stage 8-bit pipeline.
- Drives the enables, flushes and forwarding selects of IF/ID, ID/EX, EX/MEM and the MEM/WB register, including the MEM/WB bubble that gates RegWrite.
- Covers load-use stalls, taken-branch flushes, variable-latency data-memory waits (with timeout), forwarding, and a stall performance counter.

---
 rtl/pipe_hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage 8-bit pipeline.
// Mealy outputs: stage enables, flushes, MEM/WB bubble and EX forwarding selects.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic       id_use1,
  input  logic       id_use2,
  input  logic [2:0] ex_rs1,
  input  logic [2:0] ex_rs2,
  input  logic [2:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [2:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic [2:0] wb_rd,
  input  logic       wb_regwrite,
  input  logic       mem_req,
  input  logic       mem_ready,
  input  logic       branch_taken,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       memwb_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic [7:0] stall_cnt,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic [7:0] SAT     = 8'hff;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic       err_q, err_d;

  logic       mem_wait;
  logic       load_use;
  logic       hit1, hit2;
  logic [1:0] fwd_a_c, fwd_b_c;

  assign mem_wait = mem_req && !mem_ready;
  assign hit1     = id_use1 && (id_rs1 == ex_rd);
  assign hit2     = id_use2 && (id_rs2 == ex_rd);
  assign load_use = ex_memread && ex_regwrite && (hit1 || hit2);

  // EX/MEM result is newer than WB, so it wins on a double match
  always_comb begin
    fwd_a_c = 2'b00;
    if (mem_regwrite && (mem_rd == ex_rs1))
      fwd_a_c = 2'b10;
    else if (wb_regwrite && (wb_rd == ex_rs1))
      fwd_a_c = 2'b01;
  end

  always_comb begin
    fwd_b_c = 2'b00;
    if (mem_regwrite && (mem_rd == ex_rs2))
      fwd_b_c = 2'b10;
    else if (wb_regwrite && (wb_rd == ex_rs2))
      fwd_b_c = 2'b01;
  end

  always_comb begin
    state_d      = state_q;
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b1;
    idex_flush   = 1'b1;
    memwb_bubble = 1'b1;
    fwd_a        = 2'b00;
    fwd_b        = 2'b00;
    unique case (state_q)
      INIT: begin
        state_d = RUN;
      end
      RUN, MEM_WAIT: begin
        fwd_a = fwd_a_c;
        fwd_b = fwd_b_c;
        if (mem_wait) begin
          ifid_flush   = 1'b0;
          idex_flush   = 1'b0;
          memwb_bubble = 1'b1;
          state_d      = MEM_WAIT;
        end else if (branch_taken) begin
          pc_en        = 1'b1;
          ifid_en      = 1'b1;
          idex_en      = 1'b1;
          exmem_en     = 1'b1;
          memwb_bubble = 1'b0;
          state_d      = RUN;
        end else if (load_use) begin
          ifid_flush   = 1'b0;
          exmem_en     = 1'b1;
          memwb_bubble = 1'b0;
          state_d      = RUN;
        end else begin
          pc_en        = 1'b1;
          ifid_en      = 1'b1;
          idex_en      = 1'b1;
          exmem_en     = 1'b1;
          ifid_flush   = 1'b0;
          idex_flush   = 1'b0;
          memwb_bubble = 1'b0;
          state_d      = RUN;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase
  end

  // wait_cnt counts consecutive wait cycles, the entry cycle included
  always_comb begin
    wait_cnt_d = 8'd0;
    if ((state_q != INIT) && mem_wait)
      wait_cnt_d = (wait_cnt_q == SAT) ? SAT : wait_cnt_q + 8'd1;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q != INIT) && !pc_en && (stall_cnt_q != SAT))
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  always_comb begin
    err_d = err_q;
    if (wait_cnt_d >= TIMEOUT)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= 8'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: randomized and directed
// stimulus, expected outputs from a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int TO = 15;

  typedef struct packed {
    logic       rst;
    logic [2:0] id_rs1, id_rs2;
    logic       id_use1, id_use2;
    logic [2:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_regwrite, ex_memread;
    logic [2:0] mem_rd;
    logic       mem_regwrite;
    logic [2:0] wb_rd;
    logic       wb_regwrite;
    logic       mem_req, mem_ready, branch_taken;
  } stim_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] id_rs1 = '0, id_rs2 = '0;
  logic id_use1 = 0, id_use2 = 0;
  logic [2:0] ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
  logic ex_regwrite = 0, ex_memread = 0;
  logic [2:0] mem_rd = '0;
  logic mem_regwrite = 0;
  logic [2:0] wb_rd = '0;
  logic wb_regwrite = 0;
  logic mem_req = 0, mem_ready = 1, branch_taken = 0;

  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, memwb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [7:0] stall_cnt;
  logic err_timeout;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use1(id_use1), .id_use2(id_use2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // {pc,ifid,idex,exmem,ifid_fl,idex_fl,bubble,fwd_a,fwd_b,stall,err}
  typedef logic [19:0] resp_t;
  resp_t sb[$];
  int checks = 0;
  int errors = 0;

  // model state
  bit m_run = 0;
  int m_waits = 0;
  int m_stalls = 0;
  bit m_err = 0;

  function automatic logic [1:0] fsel(input stim_t s, input logic [2:0] rs);
    if (s.mem_regwrite && s.mem_rd == rs) return 2'b10;
    if (s.wb_regwrite && s.wb_rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input stim_t s);
    bit en, stall, fl1, fl2, bub, exm, mw, lu;
    logic [1:0] fa, fb;
    @(negedge clk);
    reset = s.rst;
    id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use1 = s.id_use1; id_use2 = s.id_use2;
    ex_rs1 = s.ex_rs1; ex_rs2 = s.ex_rs2; ex_rd = s.ex_rd;
    ex_regwrite = s.ex_regwrite; ex_memread = s.ex_memread;
    mem_rd = s.mem_rd; mem_regwrite = s.mem_regwrite;
    wb_rd = s.wb_rd; wb_regwrite = s.wb_regwrite;
    mem_req = s.mem_req; mem_ready = s.mem_ready;
    branch_taken = s.branch_taken;
    if (s.rst) begin
      m_run = 0; m_waits = 0; m_stalls = 0; m_err = 0;
    end
    mw = s.mem_req && !s.mem_ready;
    lu = s.ex_memread && s.ex_regwrite &&
         ((s.id_use1 && s.id_rs1 == s.ex_rd) ||
          (s.id_use2 && s.id_rs2 == s.ex_rd));
    fa = 2'b00; fb = 2'b00;
    if (!m_run) begin
      en = 0; stall = 0; exm = 0; fl1 = 1; fl2 = 1; bub = 1;
    end else begin
      fa = fsel(s, s.ex_rs1);
      fb = fsel(s, s.ex_rs2);
      if (mw) begin
        en = 0; stall = 0; exm = 0; fl1 = 0; fl2 = 0; bub = 1;
      end else if (s.branch_taken) begin
        en = 1; stall = 0; exm = 1; fl1 = 1; fl2 = 1; bub = 0;
      end else if (lu) begin
        en = 0; stall = 1; exm = 1; fl1 = 0; fl2 = 1; bub = 0;
      end else begin
        en = 1; stall = 0; exm = 1; fl1 = 0; fl2 = 0; bub = 0;
      end
    end
    // pc/ifid follow en; idex follows en except on load-use (it flushes)
    sb.push_back({en, en, en && !stall, exm, fl1, fl2, bub,
                  fa, fb, 8'(m_stalls), m_err});
    if (!s.rst) begin
      if (m_run) begin
        m_waits = mw ? ((m_waits < 255) ? m_waits + 1 : 255) : 0;
        if (m_waits >= TO) m_err = 1;
        if (!en && m_stalls < 255) m_stalls++;
      end
      m_run = 1;
    end
  endtask

  // monitor: compare whatever the DUT presents mid-cycle
  initial begin
    resp_t act, exp;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
               memwb_bubble, fwd_a, fwd_b, stall_cnt, err_timeout};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL outputs t=%0t act=%b exp=%b", $time, act, exp);
        end
      end
    end
  end

  function automatic stim_t idle();
    stim_t s = '0;
    s.mem_ready = 1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst = ($urandom_range(0, 199) == 0);
    s.id_rs1 = 3'($urandom_range(0, 3));
    s.id_rs2 = 3'($urandom_range(0, 3));
    s.id_use1 = 1'($urandom);
    s.id_use2 = 1'($urandom);
    s.ex_rs1 = 3'($urandom_range(0, 3));
    s.ex_rs2 = 3'($urandom_range(0, 3));
    s.ex_rd = 3'($urandom_range(0, 3));
    s.ex_regwrite = 1'($urandom);
    s.ex_memread = 1'($urandom);
    s.mem_rd = 3'($urandom_range(0, 3));
    s.mem_regwrite = 1'($urandom);
    s.wb_rd = 3'($urandom_range(0, 3));
    s.wb_regwrite = 1'($urandom);
    s.mem_req = 1'($urandom);
    s.mem_ready = ($urandom_range(0, 3) != 0);
    s.branch_taken = ($urandom_range(0, 4) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    s = idle(); s.rst = 1;
    step(s); step(s);
    // reset release, INIT then RUN
    s = idle();
    step(s); step(s); step(s);
    // load-use then forward from WB
    s = idle();
    s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 3;
    s.id_rs1 = 3; s.id_use1 = 1;
    step(s);
    s = idle(); s.ex_rs1 = 3; s.wb_rd = 3; s.wb_regwrite = 1;
    step(s);
    // forwarding priority
    s = idle(); s.mem_rd = 5; s.wb_rd = 5; s.ex_rs2 = 5;
    s.mem_regwrite = 1; s.wb_regwrite = 1;
    step(s);
    s.mem_regwrite = 0;
    step(s);
    // 4-cycle memory wait
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (4) step(s);
    s.mem_ready = 1;
    step(s);
    s = idle(); step(s);
    // branch held through a 3-cycle wait
    s = idle(); s.branch_taken = 1; s.mem_req = 1; s.mem_ready = 0;
    repeat (3) step(s);
    s.mem_ready = 1;
    step(s);
    s = idle(); step(s);
    // timeout, then long wait past wait counter saturation
    s = idle(); s.mem_req = 1; s.mem_ready = 0;
    repeat (20) step(s);
    s.mem_ready = 1;
    step(s);
    s = idle(); step(s); step(s);
    s.mem_req = 1; s.mem_ready = 0;
    repeat (270) step(s);
    s = idle(); s.rst = 1; step(s);
    s = idle(); step(s);
    // reset mid-stall
    s.mem_req = 1; s.mem_ready = 0;
    repeat (5) step(s);
    s.rst = 1; step(s);
    s = idle(); step(s); step(s);
    // randomized traffic
    repeat (1500) step(rnd());
    s = idle(); step(s);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain act=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
